// File: rtl/pipe_pkg.sv
// Shared types for the EX->MEM pipeline register: control bundle, payload layout, mem_reg encodings.
package pipe_pkg;

    localparam int XLEN = 32;

    // Writeback source selection carried to MEM/WB
    localparam logic [1:0] MEM_REG_ALU = 2'd0;
    localparam logic [1:0] MEM_REG_MEM = 2'd1;
    localparam logic [1:0] MEM_REG_PC4 = 2'd2;
    localparam logic [1:0] MEM_REG_IMM = 2'd3;

    typedef struct packed {
        logic       mem_en;
        logic       load;
        logic       store;
        logic       reg_write;
        logic [1:0] mem_reg;
    } exmem_ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0] alu_res;
        logic [XLEN-1:0] op_b;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_next;
        logic [31:0]     instr;
    } exmem_pl_t;

    localparam int CTRL_W = $bits(exmem_ctrl_t);

endpackage

// File: rtl/exmem_stage_reg_if.sv
// EX->MEM handshake bundle; slave modport is the stage register, master modport is the EX/MEM environment.
interface exmem_stage_reg_if
    import pipe_pkg::*;
#(
    parameter int XLEN = 32
);
    localparam int PL_W = 4*XLEN + 32;

    logic              in_valid;
    logic              in_ready;
    exmem_ctrl_t       in_ctrl;
    logic [PL_W-1:0]   in_pl;
    logic              out_valid;
    logic              out_ready;
    exmem_ctrl_t       out_ctrl;
    logic [PL_W-1:0]   out_pl;

    modport slave (
        input  in_valid, in_ctrl, in_pl, out_ready,
        output in_ready, out_valid, out_ctrl, out_pl
    );

    modport master (
        output in_valid, in_ctrl, in_pl, out_ready,
        input  in_ready, out_valid, out_ctrl, out_pl
    );

endinterface

// File: rtl/exmem_stage_reg_skid.sv
// skid_buf: generic 2-entry valid/ready buffer with registered in_ready and synchronous flush.
module skid_buf
    import pipe_pkg::*;
#(
    parameter int           W         = 8,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic         main_v_q, main_v_d;
    logic         skid_v_q, skid_v_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         acc, pop;

    assign acc = in_valid_i & ~skid_v_q;
    assign pop = main_v_q & out_ready_i;

    always_comb begin
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        main_d   = main_q;
        skid_d   = skid_q;
        if (flush_i) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (!main_v_q || pop) begin
            // Skid entry is older than anything on the input, so it always refills main first
            if (skid_v_q) begin
                main_v_d = 1'b1;
                main_d   = skid_q;
                skid_v_d = 1'b0;
            end else begin
                main_v_d = acc;
                if (acc) main_d = in_data_i;
            end
        end else if (acc) begin
            skid_v_d = 1'b1;
            skid_d   = in_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            main_q   <= RESET_VAL;
            skid_q   <= RESET_VAL;
        end else begin
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
        end
    end

    assign in_ready_o  = ~skid_v_q;
    assign out_valid_o = main_v_q;
    assign out_data_o  = main_q;

endmodule

// File: rtl/exmem_stage_reg.sv
// EX->MEM pipeline register: skid-buffered {ctrl,payload} with flush and bubble ctrl gating.
// Optional PIPE_STATS_EN adds free-running stall_cnt / bubble_cnt outputs.
module exmem_stage_reg
    import pipe_pkg::*;
#(
    parameter int                    XLEN     = 32,
    parameter logic [4*XLEN+32-1:0]  RESET_PL = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    exmem_stage_reg_if.slave   bus
`ifdef PIPE_STATS_EN
    ,
    output logic [31:0]        stall_cnt,
    output logic [31:0]        bubble_cnt
`endif
);

    localparam int PL_W = 4*XLEN + 32;
    localparam int W    = CTRL_W + PL_W;

    logic [W-1:0] in_data;
    logic [W-1:0] out_data;
    logic         out_valid;
    exmem_ctrl_t  main_ctrl;

    assign in_data = {bus.in_ctrl, bus.in_pl};

    skid_buf #(
        .W         (W),
        .RESET_VAL ({{CTRL_W{1'b0}}, RESET_PL})
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .in_valid_i  (bus.in_valid),
        .in_ready_o  (bus.in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (bus.out_ready),
        .out_data_o  (out_data)
    );

    assign main_ctrl     = exmem_ctrl_t'(out_data[W-1 -: CTRL_W]);
    assign bus.out_valid = out_valid;
    // A bubble must never write the regfile or touch memory
    assign bus.out_ctrl  = out_valid ? main_ctrl : exmem_ctrl_t'('0);
    assign bus.out_pl    = out_data[PL_W-1:0];

`ifdef PIPE_STATS_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] bubble_q, bubble_d;

    always_comb begin
        stall_d  = stall_q;
        bubble_d = bubble_q;
        if (out_valid && !bus.out_ready) stall_d  = stall_q + 32'd1;
        if (!out_valid)                  bubble_d = bubble_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
`endif

endmodule

// File: tb/tb_exmem_stage_reg.sv
// Scoreboard bench for exmem_stage_reg: stimulus pushes accepted entries, a negedge monitor pops and compares.
module tb_exmem_stage_reg;
    import pipe_pkg::*;

    localparam int PL_W = 4*XLEN + 32;
    localparam logic [PL_W-1:0] RST_PL =
        {32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_1000, 32'h0000_1004, 32'h0000_0013};

    typedef struct packed {
        exmem_ctrl_t      ctrl;
        logic [PL_W-1:0]  pl;
    } entry_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    exmem_stage_reg_if #(.XLEN(XLEN)) bus ();
`ifdef PIPE_STATS_EN
    logic [31:0] stall_cnt, bubble_cnt;
    int unsigned m_stall = 0, m_bubble = 0;
`endif

    exmem_stage_reg #(.XLEN(XLEN), .RESET_PL(RST_PL)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
`ifdef PIPE_STATS_EN
        ,
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    entry_t exp_q[$];
    int     checks = 0;
    int     errors = 0;
    bit     mon_en = 1'b0;
    bit     model_ready = 1'b1;
    bit     last_acc = 1'b0;
    bit     last_flush = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    // Monitor: the queue holds what the stage should contain, oldest first
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            chk("out_valid", 256'(bus.out_valid), 256'(exp_q.size() > 0));
            chk("in_ready", 256'(bus.in_ready), 256'(exp_q.size() < 2));
            model_ready = (exp_q.size() < 2);
`ifdef PIPE_STATS_EN
            chk("stall_cnt", 256'(stall_cnt), 256'(m_stall));
            chk("bubble_cnt", 256'(bubble_cnt), 256'(m_bubble));
            if (exp_q.size() > 0 && !bus.out_ready) m_stall++;
            if (exp_q.size() == 0) m_bubble++;
`endif
            if (exp_q.size() > 0) begin
                chk("out_ctrl", 256'(bus.out_ctrl), 256'(exp_q[0].ctrl));
                chk("out_pl", 256'(bus.out_pl), 256'(exp_q[0].pl));
                if (bus.out_ready) void'(exp_q.pop_front());
            end else begin
                chk("gated_ctrl", 256'(bus.out_ctrl), 256'(0));
            end
        end
    end

    task automatic new_input(input int p_valid, input bit force_alu, input logic [31:0] alu);
        exmem_pl_t pl;
        bus.in_valid = ($urandom_range(99) < p_valid);
        bus.in_ctrl  = exmem_ctrl_t'($urandom_range(63));
        pl.alu_res   = force_alu ? alu : $urandom;
        pl.op_b      = $urandom;
        pl.pc        = $urandom;
        pl.pc_next   = $urandom;
        pl.instr     = $urandom;
        bus.in_pl    = pl;
    endtask

    // One clock of stimulus; an offered but refused input is held stable
    task automatic step(input int p_valid, input int p_ready, input bit do_flush,
                        input bit force_alu = 1'b0, input logic [31:0] alu = '0);
        @(posedge clk);
        #1;
        if (!(bus.in_valid && !last_acc && !last_flush)) new_input(p_valid, force_alu, alu);
        bus.out_ready = ($urandom_range(99) < p_ready);
        flush = do_flush;
        @(negedge clk);
        #1;
        last_acc   = bus.in_valid && model_ready && !flush;
        last_flush = flush;
        if (flush) exp_q.delete();
        else if (last_acc) exp_q.push_back({bus.in_ctrl, bus.in_pl});
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 256'(bus.out_valid), 256'(0));
        chk({tag, "_out_ctrl"}, 256'(bus.out_ctrl), 256'(0));
        chk({tag, "_out_pl"}, 256'(bus.out_pl), 256'(RST_PL));
    endtask

    initial begin
        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_ctrl   = '0;
        bus.in_pl     = '0;
        bus.out_ready = 1'b0;
        #12;
        check_reset_outputs("por");
        chk("por_in_ready", 256'(bus.in_ready), 256'(1));
        #7;
        rst    = 1'b0;
        mon_en = 1'b1;

        // Streaming: alu_res 1,2,3 back to back
        for (int i = 1; i <= 3; i++) step(100, 100, 1'b0, 1'b1, 32'(i));
        for (int i = 0; i < 3; i++) step(0, 100, 1'b0);

        // Back-pressure: fill both entries, then drain
        for (int i = 0; i < 4; i++) step(100, 0, 1'b0);
        for (int i = 0; i < 4; i++) step(0, 100, 1'b0);

        // Flush with both entries full and a new input offered
        for (int i = 0; i < 3; i++) step(100, 0, 1'b0);
        step(100, 0, 1'b1);
        for (int i = 0; i < 3; i++) step(0, 100, 1'b0);

        // Bubbles with arbitrary ctrl on the input
        for (int i = 0; i < 5; i++) step(0, 50, 1'b0);

        // Reset mid-stream with both entries valid
        for (int i = 0; i < 3; i++) step(100, 0, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("mid");
        bus.in_valid = 1'b0;
        exp_q.delete();
        last_acc   = 1'b0;
        last_flush = 1'b0;
`ifdef PIPE_STATS_EN
        m_stall  = 0;
        m_bubble = 0;
`endif
        @(posedge clk);
        #4;
        rst = 1'b0;
        #2;
        chk("mid_in_ready", 256'(bus.in_ready), 256'(1));

        // Random traffic with occasional flushes
        for (int i = 0; i < 400; i++) step(70, 60, ($urandom_range(99) < 5));
        for (int i = 0; i < 4; i++) step(0, 100, 1'b0);

        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
